serv_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Accepts a fetch request and PC from the state/control logic, runs one Wishbone-classic read on the instruction bus, and captures the returned word.
- Delivers instruction bits [31:2] plus a one-cycle valid strobe; these drive the decoder's instruction-word and load-enable inputs.
- Handles flush (trap/debug redirect) of an in-flight fetch, and optionally an instruction-bus timeout.

---
 rtl/serv_fetch.sv | 124 ++++++++++++
 tb/tb_serv_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_fetch.sv
// rtl/serv_fetch.sv - Wishbone-classic instruction fetch stage feeding the decoder (optional timeout: SERV_FETCH_TIMEOUT_EN)
module serv_fetch #(
  parameter logic [31:0] RESET_INSN     = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [29:0] o_rdt,
  output logic        o_rdt_valid,
  output logic        o_busy,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [29:0] rdt;
  logic        rdt_valid;
  logic        fetch_err;
  logic        pending;
  logic        timeout_hit;

`ifdef SERV_FETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;

  // Wait counter: held at zero outside a bus cycle, restarted when a flush turns BUSY into DRAIN.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= 16'd0;
    end else if (state == IDLE || i_ibus_ack || (state == BUSY && i_flush)) begin
      wait_cnt <= 16'd0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Fetch sequencer: issue one bus read, capture or discard its data, remember a redirect seen while draining.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      ibus_adr  <= 32'd0;
      ibus_cyc  <= 1'b0;
      rdt       <= RESET_INSN[31:2];
      rdt_valid <= 1'b0;
      fetch_err <= 1'b0;
      pending   <= 1'b0;
    end else begin
      rdt_valid <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_fetch_req || pending) begin
            ibus_adr <= {i_pc[31:2], 2'b00};
            ibus_cyc <= 1'b1;
            pending  <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (i_ibus_ack) begin
            if (!i_flush) begin
              rdt       <= i_ibus_rdt[31:2];
              rdt_valid <= 1'b1;
            end
            ibus_cyc <= 1'b0;
            state    <= IDLE;
          end else if (i_flush) begin
            // The bus cycle must complete, so keep cyc high and swallow the data later.
            state <= DRAIN;
          end else if (timeout_hit) begin
            ibus_cyc  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (i_fetch_req) begin
            pending <= 1'b1;
          end
          if (i_ibus_ack || timeout_hit) begin
            ibus_cyc <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          ibus_cyc <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign o_ibus_adr  = ibus_adr;
  assign o_ibus_cyc  = ibus_cyc;
  assign o_rdt       = rdt;
  assign o_rdt_valid = rdt_valid;
  assign o_busy      = (state != IDLE);
  assign o_fetch_err = fetch_err;

  // Address/data byte-lane bits carry no information for word fetches.
  logic unused;
  assign unused = &{1'b0, i_pc[1:0], i_ibus_rdt[1:0], RESET_INSN[1:0], TIMEOUT_CYCLES[0]};

endmodule

// File: tb/tb_serv_fetch.sv
// tb/tb_serv_fetch.sv - self-checking bench for serv_fetch
module tb_serv_fetch;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_fetch_req;
  logic [31:0] i_pc;
  logic        i_flush;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;
  logic [29:0] o_rdt;
  logic        o_rdt_valid;
  logic        o_busy;
  logic        o_fetch_err;

  int tests = 0;
  int fails = 0;
  logic [29:0] rdt_exp;

  serv_fetch #(
    .RESET_INSN     (32'h00000013),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_fetch_req (i_fetch_req),
    .i_pc        (i_pc),
    .i_flush     (i_flush),
    .o_ibus_adr  (o_ibus_adr),
    .o_ibus_cyc  (o_ibus_cyc),
    .i_ibus_rdt  (i_ibus_rdt),
    .i_ibus_ack  (i_ibus_ack),
    .o_rdt       (o_rdt),
    .o_rdt_valid (o_rdt_valid),
    .o_busy      (o_busy),
    .o_fetch_err (o_fetch_err)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as seen by the bench: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_fetch_req = 1'b0; i_pc = 32'd0; i_flush = 1'b0;
    i_ibus_rdt = 32'd0; i_ibus_ack = 1'b0;
    #2;
    tests++; if (o_rdt !== 30'h00000004) begin fails++; $display("FAIL reset_rdt got=%h exp=%h", o_rdt, 30'h00000004); end
    tests++; if ({o_ibus_cyc, o_rdt_valid, o_busy, o_fetch_err} !== 4'b0000) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {o_ibus_cyc, o_rdt_valid, o_busy, o_fetch_err}); end
    tests++; if (o_ibus_adr !== 32'd0) begin fails++; $display("FAIL reset_adr got=%h exp=0", o_ibus_adr); end
    step();
    i_rst = 1'b0;
    step();
    step();
    tests++; if ({o_ibus_cyc, o_rdt_valid, o_busy} !== 3'b000 || o_rdt !== 30'h00000004) begin fails++; $display("FAIL idle_after_reset got=%b/%h exp=000/00000004", {o_ibus_cyc, o_rdt_valid, o_busy}, o_rdt); end
    rdt_exp = 30'h00000004;
  endtask

  task automatic test_basic();
    i_fetch_req = 1'b1; i_pc = 32'h00000103;
    step();
    i_fetch_req = 1'b0;
    tests++; if (o_ibus_adr !== 32'h00000100 || o_ibus_cyc !== 1'b1 || o_busy !== 1'b1) begin fails++; $display("FAIL basic_issue adr=%h cyc=%b busy=%b exp=00000100/1/1", o_ibus_adr, o_ibus_cyc, o_busy); end
    for (int w = 0; w < 3; w++) begin
      i_ibus_rdt = $urandom;
      step();
      tests++; if (o_ibus_cyc !== 1'b1 || o_rdt_valid !== 1'b0 || o_ibus_adr !== 32'h00000100) begin fails++; $display("FAIL basic_wait%0d cyc=%b valid=%b adr=%h exp=1/0/00000100", w, o_ibus_cyc, o_rdt_valid, o_ibus_adr); end
    end
    i_ibus_ack = 1'b1; i_ibus_rdt = 32'h00A00093;
    step();
    i_ibus_ack = 1'b0;
    tests++; if (o_rdt !== 30'h00280024 || o_rdt_valid !== 1'b1 || o_ibus_cyc !== 1'b0) begin fails++; $display("FAIL basic_ack rdt=%h valid=%b cyc=%b exp=00280024/1/0", o_rdt, o_rdt_valid, o_ibus_cyc); end
    rdt_exp = 30'h00280024;
    step();
    tests++; if (o_rdt_valid !== 1'b0 || o_rdt !== rdt_exp) begin fails++; $display("FAIL basic_hold valid=%b rdt=%h exp=0/%h", o_rdt_valid, o_rdt, rdt_exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom; b = $urandom;
    i_fetch_req = 1'b1; i_pc = 32'h00000100;
    step();
    i_fetch_req = 1'b0; i_ibus_ack = 1'b1; i_ibus_rdt = a;
    step();
    tests++; if (o_rdt_valid !== 1'b1 || o_rdt !== a[31:2]) begin fails++; $display("FAIL b2b_first valid=%b rdt=%h exp=1/%h", o_rdt_valid, o_rdt, a[31:2]); end
    i_ibus_ack = 1'b0; i_fetch_req = 1'b1; i_pc = 32'h00000104;
    step();
    tests++; if (o_ibus_cyc !== 1'b1 || o_ibus_adr !== 32'h00000104 || o_rdt_valid !== 1'b0) begin fails++; $display("FAIL b2b_reissue cyc=%b adr=%h valid=%b exp=1/00000104/0", o_ibus_cyc, o_ibus_adr, o_rdt_valid); end
    i_fetch_req = 1'b0; i_ibus_ack = 1'b1; i_ibus_rdt = b;
    step();
    i_ibus_ack = 1'b0;
    tests++; if (o_rdt_valid !== 1'b1 || o_rdt !== b[31:2] || o_ibus_cyc !== 1'b0) begin fails++; $display("FAIL b2b_second valid=%b rdt=%h cyc=%b exp=1/%h/0", o_rdt_valid, o_rdt, o_ibus_cyc, b[31:2]); end
    rdt_exp = b[31:2];
    step();
  endtask

  task automatic test_flush_drain();
    i_fetch_req = 1'b1; i_pc = 32'h00000300;
    step();
    i_fetch_req = 1'b0; i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    tests++; if (o_ibus_cyc !== 1'b1 || o_busy !== 1'b1 || o_rdt_valid !== 1'b0) begin fails++; $display("FAIL drain_enter cyc=%b busy=%b valid=%b exp=1/1/0", o_ibus_cyc, o_busy, o_rdt_valid); end
    i_fetch_req = 1'b1; i_pc = 32'h00000200;
    step();
    i_fetch_req = 1'b0;
    i_ibus_ack = 1'b1; i_ibus_rdt = 32'hDEADBEEF;
    step();
    i_ibus_ack = 1'b0;
    tests++; if (o_ibus_cyc !== 1'b0 || o_rdt_valid !== 1'b0 || o_rdt !== rdt_exp) begin fails++; $display("FAIL drain_ack cyc=%b valid=%b rdt=%h exp=0/0/%h", o_ibus_cyc, o_rdt_valid, o_rdt, rdt_exp); end
    step();
    tests++; if (o_ibus_cyc !== 1'b1 || o_ibus_adr !== 32'h00000200) begin fails++; $display("FAIL drain_pending cyc=%b adr=%h exp=1/00000200", o_ibus_cyc, o_ibus_adr); end
    i_ibus_ack = 1'b1; i_ibus_rdt = mem_word(32'h200);
    step();
    i_ibus_ack = 1'b0;
    tests++; if (o_rdt_valid !== 1'b1 || o_rdt !== mem_word(32'h200) >> 2) begin fails++; $display("FAIL drain_refetch valid=%b rdt=%h exp=1/%h", o_rdt_valid, o_rdt, mem_word(32'h200) >> 2); end
    rdt_exp = 30'(mem_word(32'h200) >> 2);
    step();
  endtask

  task automatic test_ack_flush();
    i_fetch_req = 1'b1; i_pc = 32'h00000400;
    step();
    i_fetch_req = 1'b0; i_ibus_ack = 1'b1; i_flush = 1'b1; i_ibus_rdt = 32'h12345678;
    step();
    i_ibus_ack = 1'b0; i_flush = 1'b0;
    tests++; if ({o_ibus_cyc, o_rdt_valid, o_busy} !== 3'b000 || o_rdt !== rdt_exp) begin fails++; $display("FAIL ack_flush flags=%b rdt=%h exp=000/%h", {o_ibus_cyc, o_rdt_valid, o_busy}, o_rdt, rdt_exp); end
    step();
    tests++; if (o_rdt_valid !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL ack_flush_after valid=%b busy=%b exp=0/0", o_rdt_valid, o_busy); end
  endtask

  task automatic test_timeout();
    int err_pulses;
    i_fetch_req = 1'b1; i_pc = 32'h00000500;
    step();
    i_fetch_req = 1'b0;
`ifdef SERV_FETCH_TIMEOUT_EN
    err_pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      // Cycle c has seen c-1 cycles of BUSY before this edge; cyc is high for exactly 4 cycles.
      step();
      if (o_fetch_err === 1'b1) err_pulses++;
      tests++; if (o_ibus_cyc !== (c < 4)) begin fails++; $display("FAIL timeout_cyc%0d got=%b exp=%b", c, o_ibus_cyc, (c < 4)); end
      tests++; if (o_fetch_err !== (c == 4)) begin fails++; $display("FAIL timeout_err%0d got=%b exp=%b", c, o_fetch_err, (c == 4)); end
    end
    tests++; if (err_pulses != 1 || o_rdt !== rdt_exp) begin fails++; $display("FAIL timeout_total pulses=%0d rdt=%h exp=1/%h", err_pulses, o_rdt, rdt_exp); end
`else
    err_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_fetch_err !== 1'b0 || o_ibus_cyc !== 1'b1) err_pulses++;
    end
    tests++; if (err_pulses != 0) begin fails++; $display("FAIL no_timeout bad_cycles=%0d exp=0", err_pulses); end
    i_ibus_ack = 1'b1; i_ibus_rdt = mem_word(32'h500);
    step();
    i_ibus_ack = 1'b0;
    tests++; if (o_rdt_valid !== 1'b1 || o_rdt !== mem_word(32'h500) >> 2) begin fails++; $display("FAIL late_ack valid=%b rdt=%h exp=1/%h", o_rdt_valid, o_rdt, mem_word(32'h500) >> 2); end
    rdt_exp = 30'(mem_word(32'h500) >> 2);
`endif
    step();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int mode;
    int waits;
    int flush_at;
    int delivered;
    int expected_deliveries;
    int errs;
    delivered = 0; expected_deliveries = 0; errs = 0;
    for (int n = 0; n < 40; n++) begin
      pc = $urandom;
      mode = $urandom_range(0, 2);
      waits = $urandom_range(0, 3);
      if (mode == 1 && waits == 0) waits = 1;
      flush_at = $urandom_range(0, waits > 0 ? waits - 1 : 0);
      i_fetch_req = 1'b1; i_pc = pc;
      step();
      i_fetch_req = 1'b0; i_pc = $urandom;
      if (o_ibus_cyc !== 1'b1 || o_ibus_adr !== {pc[31:2], 2'b00}) begin
        errs++; $display("FAIL rand_issue n=%0d cyc=%b adr=%h exp=1/%h", n, o_ibus_cyc, o_ibus_adr, {pc[31:2], 2'b00});
      end
      for (int w = 0; w < waits; w++) begin
        i_ibus_rdt = $urandom;
        i_flush = (mode == 1 && w == flush_at);
        i_fetch_req = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        i_flush = 1'b0; i_fetch_req = 1'b0;
        if (o_ibus_cyc !== 1'b1 || o_rdt_valid !== 1'b0 || o_ibus_adr !== {pc[31:2], 2'b00}) begin
          errs++; $display("FAIL rand_wait n=%0d cyc=%b valid=%b adr=%h", n, o_ibus_cyc, o_rdt_valid, o_ibus_adr);
        end
      end
      i_ibus_ack = 1'b1; i_ibus_rdt = mem_word(pc); i_flush = (mode == 2);
      step();
      i_ibus_ack = 1'b0; i_flush = 1'b0;
      if (o_rdt_valid === 1'b1) delivered++;
      if (mode == 0) begin
        expected_deliveries++;
        rdt_exp = 30'(mem_word(pc) >> 2);
      end
      if (o_ibus_cyc !== 1'b0 || o_rdt_valid !== (mode == 0) || o_rdt !== rdt_exp) begin
        errs++; $display("FAIL rand_ack n=%0d mode=%0d cyc=%b valid=%b rdt=%h exp=0/%b/%h", n, mode, o_ibus_cyc, o_rdt_valid, o_rdt, (mode == 0), rdt_exp);
      end
      i_flush = 1'($urandom_range(0, 1)); i_ibus_ack = 1'($urandom_range(0, 1)); i_ibus_rdt = $urandom;
      step();
      i_flush = 1'b0; i_ibus_ack = 1'b0;
      if ({o_ibus_cyc, o_rdt_valid, o_busy} !== 3'b000 || o_rdt !== rdt_exp) begin
        errs++; $display("FAIL rand_idle n=%0d flags=%b rdt=%h exp=000/%h", n, {o_ibus_cyc, o_rdt_valid, o_busy}, o_rdt, rdt_exp);
      end
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL rand_sequence bad_checks=%0d exp=0", errs); end
    tests++; if (delivered != expected_deliveries) begin fails++; $display("FAIL rand_deliveries got=%0d exp=%0d", delivered, expected_deliveries); end
  endtask

  task automatic test_reset_mid_fetch();
    i_fetch_req = 1'b1; i_pc = 32'h00000600;
    step();
    i_fetch_req = 1'b0;
    i_rst = 1'b1;
    #1;
    tests++; if ({o_ibus_cyc, o_busy} !== 2'b00 || o_rdt !== 30'h00000004) begin fails++; $display("FAIL rst_mid flags=%b rdt=%h exp=00/00000004", {o_ibus_cyc, o_busy}, o_rdt); end
    step();
    i_rst = 1'b0;
    i_ibus_ack = 1'b1; i_ibus_rdt = 32'hFFFFFFFF;
    step();
    i_ibus_ack = 1'b0;
    tests++; if ({o_ibus_cyc, o_rdt_valid} !== 2'b00 || o_rdt !== 30'h00000004) begin fails++; $display("FAIL rst_late_ack flags=%b rdt=%h exp=00/00000004", {o_ibus_cyc, o_rdt_valid}, o_rdt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush_drain();
    test_ack_flush();
    test_timeout();
    test_random();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
